svm_score: RTL and testbench
============================

SVM_SCORE -- requirements
Module: svm_score

Interface
REQ-001 Parameters SHALL be (name, default, meaning): SW_W, 11, slide-window index width; PSUM_W, 24, signed per-block partial dot-product width; ACC_W, 32, signed accumulator/score width; N_BLK, 105, blocks per slide window.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock; rst in 1 reset (synchronous, active-low); i_valid in 1 partial-sum beat valid; i_ready out 1 beat accepted when high with i_valid; i_psum in PSUM_W signed block partial sum from PE; i_sw_id in SW_W window index of beat; i_last in 1 last block of window; cfg_bias in ACC_W signed SVM bias; cfg_thresh in ACC_W signed decision threshold; o_valid out 1 result valid; o_ready in 1 downstream accepts result; o_score out ACC_W signed window score; o_detect out 1 score above threshold; o_sw_id out SW_W window index of result; o_err out 1 block-count mismatch on this window.

Function
REQ-003 Beat SHALL be accepted iff i_valid & i_ready; i_ready SHALL equal ~o_valid | o_ready (combinational, single output register).
REQ-004 blk_cnt (ceil(log2(N_BLK)) bits) SHALL count accepted beats of the current window, reset to 0 on window close.
REQ-005 On accepted beat with blk_cnt==0, acc_next SHALL be sign-extended i_psum; otherwise acc_next = acc + sext(i_psum), saturated to ACC_W signed range.
REQ-006 Window SHALL close on an accepted beat with i_last=1 or with blk_cnt==N_BLK-1, whichever first.
REQ-007 On close, next cycle: o_valid=1, o_score = sat(acc_next + cfg_bias), o_detect = (o_score > cfg_thresh, signed), o_sw_id = i_sw_id of closing beat, o_err = (i_last != (blk_cnt==N_BLK-1)); acc and blk_cnt SHALL clear.
REQ-008 Latency: result SHALL appear exactly one cycle after the closing beat is accepted.
REQ-009 o_valid SHALL stay high with o_score/o_detect/o_sw_id/o_err stable until o_valid & o_ready; with no new close in that cycle o_valid SHALL drop next cycle.
REQ-010 Result accepted and new window closed in same cycle: new result SHALL load, o_valid stays 1 (back-to-back, no bubble).
REQ-011 Non-closing beats SHALL be accepted while o_valid=1 only if o_ready=1 (per REQ-003); no beat SHALL be dropped or duplicated.
REQ-012 i_sw_id of non-closing beats SHALL be ignored; cfg_bias/cfg_thresh SHALL be sampled only at close.
REQ-013 Saturation SHALL clamp to +2^(ACC_W-1)-1 / -2^(ACC_W-1); no wrap-around.

Reset
REQ-014 When rst=0 at a clk edge: acc=0, blk_cnt=0, o_valid=0, o_score=0, o_detect=0, o_sw_id=0, o_err=0.
REQ-015 Reset mid-window SHALL discard the partial window and any pending result; first beat after reset starts a new window.
REQ-016 i_ready SHALL be 1 during and after reset (o_valid=0).

Structure
REQ-017 Shared package svm_pkg SHALL hold SW_W, PSUM_W, ACC_W, N_BLK defaults, shared with svm_ctrl and PE.
REQ-018 One sub-module sat_add (signed saturating adder, width parameter) SHALL be instantiated twice (accumulate, bias add).
REQ-019 No memories; registers only; single clock domain.

Verification (N_BLK=4, ACC_W=32, PSUM_W=24)
REQ-020 Psums 10,20,30,40, i_last on 4th, sw_id=7, bias=-50, thresh=40, o_ready=1 -> one cycle later o_valid=1, o_score=50, o_detect=1, o_sw_id=7, o_err=0.
REQ-021 Same beats, bias=-60, thresh=40 -> o_score=40, o_detect=0 (strict greater-than).
REQ-022 o_ready=0 for 5 cycles after result while next window streams -> i_ready=0, outputs stable, no beats lost; result transfers when o_ready=1, then second window correct.
REQ-023 i_last on 2nd beat (psums 5,6) -> o_score=11+bias, o_err=1; 4 beats with no i_last -> closes after 4th, o_err=1.
REQ-024 Psums 0x7FFFFF x4, bias=0x7FFFFFFF -> o_score=0x7FFFFFFF (saturated, not wrapped); psums -0x800000 x4, bias=0x80000000 -> o_score=0x80000000.
REQ-025 rst=0 asserted after 2 beats, released, then 4 beats of 1 -> o_score=4+bias, o_err=0; no result from aborted window.

Source files
------------

// File: rtl/svm_pkg.sv
// svm_pkg: shared default widths and block count for the SVM scoring path.
package svm_pkg;
   localparam int DEF_SW_W   = 11;
   localparam int DEF_PSUM_W = 24;
   localparam int DEF_ACC_W  = 32;
   localparam int DEF_N_BLK  = 105;
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/svm_score_if.sv
// svm_score_if: partial-sum beat input and window result output handshakes.
interface svm_score_if
   import svm_pkg::*;
#(
   parameter int SW_W   = DEF_SW_W,
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int ACC_W  = DEF_ACC_W
) ();
   logic                     i_valid;
   logic                     i_ready;
   logic signed [PSUM_W-1:0] i_psum;
   logic        [SW_W-1:0]   i_sw_id;
   logic                     i_last;
   logic                     o_valid;
   logic                     o_ready;
   logic signed [ACC_W-1:0]  o_score;
   logic                     o_detect;
   logic        [SW_W-1:0]   o_sw_id;
   logic                     o_err;
   modport master (
      output i_valid, i_psum, i_sw_id, i_last, o_ready,
      input  i_ready, o_valid, o_score, o_detect, o_sw_id, o_err
   );
   modport slave (
      input  i_valid, i_psum, i_sw_id, i_last, o_ready,
      output i_ready, o_valid, o_score, o_detect, o_sw_id, o_err
   );
endinterface

// File: rtl/svm_score_sat_add.sv
// sat_add: signed adder that clamps to the W-bit range instead of wrapping.
module sat_add #(
   parameter int W = 32
) (
   input  logic signed [W-1:0] i_a,
   input  logic signed [W-1:0] i_b,
   output logic signed [W-1:0] o_sum
);
   logic [W:0] w_sum;
   assign w_sum = {i_a[W-1], i_a} + {i_b[W-1], i_b};
   assign o_sum = (w_sum[W] != w_sum[W-1])
                ? (w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                : w_sum[W-1:0];
endmodule

// File: rtl/svm_score.sv
// svm_score: accumulates per-block partial sums into a window score, adds bias and thresholds it.
module svm_score
   import svm_pkg::*;
#(
   parameter int SW_W   = DEF_SW_W,
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int N_BLK  = DEF_N_BLK
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [ACC_W-1:0] cfg_bias,
   input  logic signed [ACC_W-1:0] cfg_thresh,
   svm_score_if.slave              bus
);
   localparam int CNT_W = cnt_w(N_BLK);
   logic signed [ACC_W-1:0] r_acc, r_score;
   logic        [CNT_W-1:0] r_blk_cnt;
   logic                    r_valid, r_detect, r_err;
   logic        [SW_W-1:0]  r_sw_id;
   logic signed [ACC_W-1:0] w_psum_ext, w_acc_base, w_acc_next, w_score;
   logic                    w_fire, w_full, w_close;
   assign w_psum_ext = ACC_W'(bus.i_psum);
   assign w_acc_base = (r_blk_cnt == '0) ? '0 : r_acc;
   assign w_fire     = bus.i_valid & bus.i_ready;
   assign w_full     = r_blk_cnt == CNT_W'(N_BLK - 1);
   assign w_close    = w_fire & (bus.i_last | w_full);
   sat_add #(.W(ACC_W)) u_acc (.i_a(w_acc_base), .i_b(w_psum_ext), .o_sum(w_acc_next));
   sat_add #(.W(ACC_W)) u_bias (.i_a(w_acc_next), .i_b(cfg_bias), .o_sum(w_score));
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc     <= '0;
         r_blk_cnt <= '0;
         r_valid   <= 1'b0;
         r_score   <= '0;
         r_detect  <= 1'b0;
         r_sw_id   <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_fire) begin
            r_acc     <= w_close ? '0 : w_acc_next;
            r_blk_cnt <= w_close ? '0 : r_blk_cnt + CNT_W'(1);
         end
         if (w_close) begin
            r_valid  <= 1'b1;
            r_score  <= w_score;
            r_detect <= w_score > cfg_thresh;
            r_sw_id  <= bus.i_sw_id;
            r_err    <= bus.i_last != w_full;
         end else if (bus.o_ready) begin
            r_valid  <= 1'b0;
         end
      end
   end
   assign bus.i_ready  = ~r_valid | bus.o_ready;
   assign bus.o_valid  = r_valid;
   assign bus.o_score  = r_score;
   assign bus.o_detect = r_detect;
   assign bus.o_sw_id  = r_sw_id;
   assign bus.o_err    = r_err;
endmodule

// File: tb/tb_svm_score.sv
// tb_svm_score: table-driven windows with a result scoreboard, plus backpressure and reset sequences.
module tb_svm_score;
   localparam int SW_W = 11, PSUM_W = 24, ACC_W = 32, N_BLK = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic signed [ACC_W-1:0] cfg_bias = '0, cfg_thresh = '0;
   always #5 clk = ~clk;
   svm_score_if #(.SW_W(SW_W), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) bus ();
   svm_score #(.SW_W(SW_W), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .N_BLK(N_BLK)) dut (
      .clk(clk), .rst(rst), .cfg_bias(cfg_bias), .cfg_thresh(cfg_thresh), .bus(bus)
   );
   typedef struct {
      logic signed [ACC_W-1:0] score;
      logic                    detect;
      logic [SW_W-1:0]         sw_id;
      logic                    err;
   } res_t;
   typedef struct {
      int                          n;
      logic [3:0][PSUM_W-1:0]      p;
      logic                        last;
      logic [SW_W-1:0]             sw;
      logic signed [ACC_W-1:0]     bias;
      logic signed [ACC_W-1:0]     thr;
      res_t                        exp;
   } vec_t;
   res_t q[$];
   vec_t tv[7];
   int n_chk = 0, n_fail = 0;
   logic r_stall = 1'b0;
   res_t r_held, e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && r_stall) begin
         check("hold_valid", bus.o_valid, 1);
         check("hold_score", bus.o_score, r_held.score);
         check("hold_detect", bus.o_detect, r_held.detect);
         check("hold_sw_id", bus.o_sw_id, r_held.sw_id);
         check("hold_err", bus.o_err, r_held.err);
      end
      if (rst && bus.o_valid && bus.o_ready) begin
         if (q.size() == 0) check("unexpected_result", 1, 0);
         else begin
            e = q.pop_front();
            check("score", bus.o_score, e.score);
            check("detect", bus.o_detect, e.detect);
            check("sw_id", bus.o_sw_id, e.sw_id);
            check("err", bus.o_err, e.err);
         end
      end
      r_stall <= rst && bus.o_valid && !bus.o_ready;
      r_held  <= '{bus.o_score, bus.o_detect, bus.o_sw_id, bus.o_err};
   end

   task automatic setv(input int i, input int n, input logic [PSUM_W-1:0] p0, p1, p2, p3,
                       input logic last, input logic [SW_W-1:0] sw,
                       input logic signed [ACC_W-1:0] bias, thr, score,
                       input logic det, input logic err);
      tv[i].n = n;
      tv[i].p = {p3, p2, p1, p0};
      tv[i].last = last;
      tv[i].sw = sw;
      tv[i].bias = bias;
      tv[i].thr = thr;
      tv[i].exp = '{score, det, sw, err};
   endtask

   task automatic beat(input logic [PSUM_W-1:0] p, input logic [SW_W-1:0] sw, input logic last);
      int n = 0;
      bus.i_valid = 1'b1;
      bus.i_psum = p;
      bus.i_sw_id = sw;
      bus.i_last = last;
      while (!bus.i_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("beat_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input vec_t v);
      cfg_bias = v.bias;
      cfg_thresh = v.thr;
      q.push_back(v.exp);
      for (int i = 0; i < v.n; i++)
         beat(v.p[i], (i == v.n - 1) ? v.sw : SW_W'($urandom), (i == v.n - 1) & v.last);
      bus.i_valid = 1'b0;
      bus.i_last = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) check("drain_timeout", q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      vec_t va, vb, vr;
      bus.i_valid = 1'b0;
      bus.i_psum = '0;
      bus.i_sw_id = '0;
      bus.i_last = 1'b0;
      bus.o_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_i_ready", bus.i_ready, 1);
      check("rst_o_valid", bus.o_valid, 0);
      check("rst_o_score", bus.o_score, 0);
      check("rst_o_detect", bus.o_detect, 0);
      check("rst_o_sw_id", bus.o_sw_id, 0);
      check("rst_o_err", bus.o_err, 0);
      rst = 1'b1;
      setv(0, 4, 10, 20, 30, 40, 1, 7, -50, 40, 50, 1, 0);
      setv(1, 4, 10, 20, 30, 40, 1, 7, -60, 40, 40, 0, 0);
      setv(2, 2, 5, 6, 0, 0, 1, 3, 100, 0, 111, 1, 1);
      setv(3, 4, 1, 2, 3, 4, 0, 9, 0, 100, 10, 0, 1);
      setv(4, 4, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1, 12, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 1, 0);
      setv(5, 4, 24'h800000, 24'h800000, 24'h800000, 24'h800000, 1, 13, 32'h80000000, 0, 32'h80000000, 0, 0);
      setv(6, 2, -100, 50, 0, 0, 1, 2047, 0, -60, -50, 1, 1);
      for (int i = 0; i < 7; i++) run(tv[i]);
      drain();
      setv(0, 4, 10, 20, 30, 40, 1, 1, 0, 0, 100, 1, 0);
      setv(1, 4, 1, 2, 3, 4, 1, 5, 1, 0, 11, 1, 0);
      va = tv[0];
      vb = tv[1];
      bus.o_ready = 1'b0;
      fork
         begin
            run(va);
            run(vb);
         end
         begin
            int n = 0;
            while (!bus.o_valid && n < 100) begin
               @(negedge clk);
               n++;
            end
            repeat (5) begin
               check("stall_i_ready", bus.i_ready, 0);
               @(negedge clk);
            end
            @(posedge clk);
            #2 bus.o_ready = 1'b1;
         end
      join
      drain();
      cfg_bias = 3;
      beat(100, 0, 0);
      beat(200, 0, 0);
      bus.i_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_o_valid", bus.o_valid, 0);
      check("midrst_i_ready", bus.i_ready, 1);
      rst = 1'b1;
      setv(2, 4, 1, 1, 1, 1, 1, 4, 3, 10, 7, 0, 0);
      vr = tv[2];
      run(vr);
      drain();
      check("idle_o_valid", bus.o_valid, 0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
